// File: rtl/tt_um_seq_addsub.sv
// Byte-serial adder/subtractor: two WIDTH-bit operands arrive LSB byte first,
// the result is computed in one cycle and handed back byte by byte on ack.
module tt_um_seq_addsub #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NBYTES = WIDTH / 8;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_CALC   = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_idx;
  logic [1:0]         w_idx_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_mode;
  logic               r_carry;
  logic               r_zero;
  logic [WIDTH:0]     w_full;
  logic [7:0]         w_out_byte;
  logic               w_in_out;

  logic w_strobe;
  logic w_ack;
  logic w_mode;
  logic w_clear;
  logic w_last;
  logic w_unused;

  assign w_strobe = uio_in[0];
  assign w_ack    = uio_in[1];
  assign w_mode   = uio_in[2];
  assign w_clear  = uio_in[3];
  assign w_unused = ^uio_in[7:4];
  assign w_last   = (r_idx == LAST_IDX);
  assign uio_oe   = 8'hF0;

  // State and byte-index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD_A;
      r_idx   <= 2'd0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end else begin
      r_state <= r_state;
      r_idx   <= r_idx;
    end
  end

  // Next-state logic; clear wins over strobe and ack
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_clear) begin
      w_state_nxt = S_LOAD_A;
      w_idx_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_LOAD_A: begin
          if (w_strobe && w_last) begin
            w_state_nxt = S_LOAD_B;
            w_idx_nxt   = 2'd0;
          end else if (w_strobe) begin
            w_idx_nxt = r_idx + 2'd1;
          end else begin
            w_idx_nxt = r_idx;
          end
        end
        S_LOAD_B: begin
          if (w_strobe && w_last) begin
            w_state_nxt = S_CALC;
            w_idx_nxt   = 2'd0;
          end else if (w_strobe) begin
            w_idx_nxt = r_idx + 2'd1;
          end else begin
            w_idx_nxt = r_idx;
          end
        end
        S_CALC: begin
          w_state_nxt = S_OUT;
          w_idx_nxt   = 2'd0;
        end
        S_OUT: begin
          if (w_ack && w_last) begin
            w_state_nxt = S_LOAD_A;
            w_idx_nxt   = 2'd0;
          end else if (w_ack) begin
            w_idx_nxt = r_idx + 2'd1;
          end else begin
            w_idx_nxt = r_idx;
          end
        end
        default: begin
          w_state_nxt = S_LOAD_A;
          w_idx_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Extra top bit carries the add carry-out, or the borrow when A < B
  always_comb begin
    if (r_mode) begin
      w_full = {1'b0, r_a} - {1'b0, r_b};
    end else begin
      w_full = {1'b0, r_a} + {1'b0, r_b};
    end
  end

  // Operand capture, mode latch and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (ena && !w_clear) begin
      case (r_state)
        S_LOAD_A: begin
          if (w_strobe) begin
            for (int k = 0; k < NBYTES; k++) begin
              if (r_idx == 2'(k)) begin
                r_a[k*8 +: 8] <= ui_in;
              end
            end
            if (r_idx == 2'd0) begin
              r_mode <= w_mode;
            end
          end
        end
        S_LOAD_B: begin
          if (w_strobe) begin
            for (int k = 0; k < NBYTES; k++) begin
              if (r_idx == 2'(k)) begin
                r_b[k*8 +: 8] <= ui_in;
              end
            end
          end
        end
        S_CALC: begin
          r_res   <= w_full[WIDTH-1:0];
          r_carry <= w_full[WIDTH];
          r_zero  <= (w_full[WIDTH-1:0] == '0);
        end
        S_OUT: begin
          r_res <= r_res;
        end
        default: begin
          r_res <= r_res;
        end
      endcase
    end
  end

  // Output decode from registered state, index and result only
  always_comb begin
    w_in_out   = (r_state == S_OUT);
    w_out_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == 2'(k)) begin
        w_out_byte = r_res[k*8 +: 8];
      end
    end
    if (w_in_out) begin
      uo_out  = w_out_byte;
      uio_out = {1'b1, r_carry, r_zero, 1'b0, 4'b0000};
    end else begin
      uo_out  = 8'h00;
      uio_out = {3'b000, (r_state == S_LOAD_B), 4'b0000};
    end
  end

endmodule

// File: tb/tb_tt_um_seq_addsub.sv
// Directed bench for tt_um_seq_addsub (WIDTH=16) with a queue scoreboard of
// expected results built from plain integer arithmetic.
module tb_tt_um_seq_addsub;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
  } exp_t;

  exp_t sb[$];

  tt_um_seq_addsub #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic mode);
    ui_in  = b;
    uio_in = {4'b0000, 1'b0, mode, 1'b0, 1'b1};
    tick();
    uio_in = 8'h00;
  endtask

  // Expected values from 32-bit integer arithmetic
  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic mode);
    exp_t e;
    int unsigned s;
    if (mode) begin
      s   = (32'(a) + 32'h10000 - 32'(b)) & 32'hFFFF;
      e.c = (a < b);
    end else begin
      s   = 32'(a) + 32'(b);
      e.c = (s > 32'hFFFF);
    end
    e.r = s[15:0];
    e.z = (e.r == 16'h0000);
    sb.push_back(e);
  endtask

  task automatic finish_calc(input string tag);
    check({tag, "_calc_valid"}, 32'(uio_out[7]), 32'd0);
    tick();
  endtask

  task automatic load_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic mode);
    push_exp(a, b, mode);
    send_byte(a[7:0], mode);
    send_byte(a[15:8], mode);
    check({tag, "_expB"}, 32'(uio_out[4]), 32'd1);
    send_byte(b[7:0], mode);
    send_byte(b[15:8], mode);
    finish_calc(tag);
  endtask

  task automatic read_result(input string tag);
    exp_t e;
    logic [15:0] r;
    n_tests++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty queue required entry", tag);
      return;
    end
    e = sb.pop_front();
    r = e.r;
    check({tag, "_carry"}, 32'(uio_out[6]), 32'(e.c));
    check({tag, "_zero"}, 32'(uio_out[5]), 32'(e.z));
    for (int k = 0; k < 2; k++) begin
      check({tag, "_valid"}, 32'(uio_out[7]), 32'd1);
      check({tag, "_byte"}, 32'(uo_out), 32'(r[k*8 +: 8]));
      uio_in = 8'h02;
      tick();
      uio_in = 8'h00;
    end
    check({tag, "_idle_uio"}, 32'(uio_out), 32'h00);
    check({tag, "_idle_uo"}, 32'(uo_out), 32'h00);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    check("rst_uo", 32'(uo_out), 32'h00);
    check("rst_uio", 32'(uio_out), 32'h00);
    check("rst_oe", 32'(uio_oe), 32'hF0);
    rst_n = 1'b1;
    tick();
    check("post_rst_uio", 32'(uio_out), 32'h00);

    // Add with strobe ignored in OUT
    load_op("add", 16'h1234, 16'h0FFF, 1'b0);
    check("add_first", 32'(uo_out), 32'h33);
    uio_in = 8'h01;
    ui_in  = 8'h99;
    tick();
    uio_in = 8'h00;
    check("strobe_in_out", 32'(uo_out), 32'h33);
    read_result("add");

    load_op("ovf", 16'hFFFF, 16'h0001, 1'b0);
    read_result("ovf");

    load_op("sub_neg", 16'h0005, 16'h0007, 1'b1);
    read_result("sub_neg");
    load_op("sub_pos", 16'h0007, 16'h0005, 1'b1);
    read_result("sub_pos");

    // Clear with strobe mid-B
    send_byte(8'hAA, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
    check("clr_pre_expB", 32'(uio_out[4]), 32'd1);
    ui_in  = 8'h77;
    uio_in = 8'h09;
    tick();
    uio_in = 8'h00;
    check("clr_expB", 32'(uio_out), 32'h00);
    load_op("clr_add", 16'h0001, 16'h0001, 1'b0);
    read_result("clr_add");

    // Asynchronous reset mid-OUT
    load_op("arst", 16'h1111, 16'h2222, 1'b0);
    check("arst_valid", 32'(uio_out[7]), 32'd1);
    void'(sb.pop_front());
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_uo", 32'(uo_out), 32'h00);
    check("arst_uio", 32'(uio_out), 32'h00);
    #2;
    rst_n = 1'b1;
    tick();
    load_op("post_arst", 16'h0102, 16'h0304, 1'b0);
    read_result("post_arst");

    // ena low in LOAD_B with strobe toggling
    push_exp(16'h4321, 16'h1001, 1'b0);
    send_byte(8'h21, 1'b0);
    send_byte(8'h43, 1'b0);
    send_byte(8'h01, 1'b0);
    ena   = 1'b0;
    ui_in = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      uio_in = (i % 2 == 0) ? 8'h01 : 8'h00;
      tick();
    end
    uio_in = 8'h00;
    check("ena_hold_expB", 32'(uio_out[4]), 32'd1);
    ena = 1'b1;
    send_byte(8'h10, 1'b0);
    finish_calc("ena");
    read_result("ena");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
